// File: rtl/uart_boot_loader.sv
// UART boot loader: receives an A5/LEN/words(/CHK) frame and writes 16-bit words into BSRAM.
// Optional checksum byte enabled by defining UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int unsigned CLK_HZ      = 27000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned MAX_WORDS   = 2048,
  parameter int unsigned TIMEOUT_CYC = 2700000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              mem_we,
  output logic              boot_mode,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned BitCntW    = $clog2(ClksPerBit + 1);
  localparam int unsigned ToCntW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {FrSync, FrLenH, FrLenL, FrWhi, FrWlo, FrChk, FrDone} fr_state_e;

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  localparam fr_state_e FrAfterWords = FrChk;
`else
  localparam fr_state_e FrAfterWords = FrDone;
`endif

  logic rx_meta_q, rx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_q      <= rx_meta_q;
    end
  end

  rx_state_e          rx_state_q, rx_state_d;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               byte_valid_q;
  logic               bit_tick, half_tick;

  assign bit_tick  = (bit_cnt_q == BitCntW'(ClksPerBit - 1));
  assign half_tick = (bit_cnt_q == BitCntW'(HalfBit - 1));

  always_ff @(posedge clk) begin
    if (rst) rx_state_q <= RxIdle;
    else     rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RxIdle:  if (!rx_q) rx_state_d = RxStart;
      RxStart: if (half_tick) rx_state_d = rx_q ? RxIdle : RxData;
      RxData:  if (bit_tick && bit_idx_q == 3'd7) rx_state_d = RxStop;
      RxStop:  if (bit_tick) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  // Bit timer restarts on every state change so each phase counts from its own entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (rx_state_q == RxIdle || rx_state_d != rx_state_q || bit_tick) bit_cnt_q <= '0;
      else bit_cnt_q <= bit_cnt_q + 1'b1;
      if (rx_state_q == RxStart) begin
        bit_idx_q <= '0;
      end else if (rx_state_q == RxData && bit_tick) begin
        shift_q   <= {rx_q, shift_q[7:1]};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (rx_state_q == RxStop && bit_tick && rx_q) byte_valid_q <= 1'b1;
    end
  end

  fr_state_e         fr_state_q, fr_state_d;
  logic [7:0]        len_hi_q, hi_q;
  logic [15:0]       len_q, len_now;
  logic [ADDR_W:0]   cnt_q, cnt_inc;
  logic [ToCntW-1:0] to_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_din_q;
  logic              mem_we_q, err_q;
  logic              timeout, last_word, len_too_big, idle_state;

  assign len_now     = {len_hi_q, shift_q};
  assign cnt_inc     = cnt_q + 1'b1;
  assign last_word   = (32'(cnt_inc) == 32'(len_q));
  assign len_too_big = (32'(len_now) > MAX_WORDS);
  assign idle_state  = (fr_state_q == FrSync) || (fr_state_q == FrDone);
  assign timeout     = !idle_state && (to_cnt_q == ToCntW'(TIMEOUT_CYC - 1));

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       chk_ok;
  assign chk_ok = (shift_q == chk_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) fr_state_q <= FrSync;
    else     fr_state_q <= fr_state_d;
  end

  always_comb begin
    fr_state_d = fr_state_q;
    if (byte_valid_q) begin
      case (fr_state_q)
        FrSync: if (shift_q == 8'hA5) fr_state_d = FrLenH;
        FrLenH: fr_state_d = FrLenL;
        FrLenL: begin
          if (len_too_big)         fr_state_d = FrSync;
          else if (len_now == '0)  fr_state_d = FrAfterWords;
          else                     fr_state_d = FrWhi;
        end
        FrWhi: fr_state_d = FrWlo;
        FrWlo: fr_state_d = last_word ? FrAfterWords : FrWhi;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        FrChk: fr_state_d = chk_ok ? FrDone : FrSync;
`endif
        default: fr_state_d = fr_state_q;
      endcase
    end else if (timeout) begin
      fr_state_d = FrSync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_q   <= '0;
      hi_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (byte_valid_q || idle_state) to_cnt_q <= '0;
      else                            to_cnt_q <= to_cnt_q + 1'b1;
      if (timeout && !byte_valid_q) err_q <= 1'b1;
      if (byte_valid_q) begin
        case (fr_state_q)
          FrSync: if (shift_q == 8'hA5) begin
            err_q <= 1'b0;
            cnt_q <= '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            chk_q <= '0;
`endif
          end
          FrLenH: len_hi_q <= shift_q;
          FrLenL: begin
            len_q <= len_now;
            if (len_too_big) err_q <= 1'b1;
          end
          FrWhi: begin
            hi_q <= shift_q;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            chk_q <= chk_q + shift_q;
`endif
          end
          FrWlo: begin
            mem_we_q   <= 1'b1;
            mem_din_q  <= {hi_q, shift_q};
            mem_addr_q <= cnt_q[ADDR_W-1:0];
            cnt_q      <= cnt_inc;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            chk_q      <= chk_q + shift_q;
`endif
          end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
          FrChk: if (!chk_ok) err_q <= 1'b1;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    done       = (fr_state_q == FrDone);
    boot_mode  = (fr_state_q != FrDone);
    mem_addr   = mem_addr_q;
    mem_din    = mem_din_q;
    mem_we     = mem_we_q;
    err        = err_q;
    word_count = cnt_q;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader; expected BSRAM writes are queued and checked as they occur.
module tb_uart_boot_loader;
  localparam int unsigned AddrW = 11;
  localparam int unsigned Bit   = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             uart_rx = 1'b1;
  logic [AddrW-1:0] mem_addr;
  logic [15:0]      mem_din;
  logic             mem_we, boot_mode, done, err;
  logic [AddrW:0]   word_count;

  int vectors = 0;
  int miscompares = 0;
  logic [26:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic        prev_we = 1'b0;

  uart_boot_loader #(
    .CLK_HZ(1000000), .BAUD(100000), .ADDR_W(AddrW), .MAX_WORDS(2048), .TIMEOUT_CYC(500)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .boot_mode(boot_mode), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the next queued write and last one cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      check("we_width", 32'(prev_we), 32'd0);
      check("unexpected_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [26:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[26:16]));
        check("write_data", 32'(mem_din), 32'(e[15:0]));
      end
    end
    prev_we <= mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (Bit) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (Bit) @(negedge clk);
    end
    uart_rx = stop;
    repeat (Bit) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * Bit) @(negedge clk);
  endtask

  task automatic send_queued();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic add_chk(input logic [7:0] c);
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    tx_q.push_back(c);
`else
    if (c == 8'h00) tx_q.delete(tx_q.size()); // no-op keeps the argument used
`endif
  endtask

  task automatic step1_frame();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h02);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'hAB); tx_q.push_back(8'hCD);
    add_chk(8'hBE);
    exp_q.push_back({11'd0, 16'h1234});
    exp_q.push_back({11'd1, 16'hABCD});
    send_queued();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic bm, input logic e,
                              input int wc);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_boot_mode"}, 32'(boot_mode), 32'(bm));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_word_count"}, 32'(word_count), 32'(wc));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_status(tag, 1'b0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    // Step 1: two-word frame.
    step1_frame();
    check_status("s1", 1'b1, 1'b0, 1'b0, 2);

    // Step 2: leading junk ignored.
    do_reset();
    tx_q = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h01, 8'h55, 8'hAA};
    add_chk(8'hFF);
    exp_q.push_back({11'd0, 16'h55AA});
    send_queued();
    check_status("s2", 1'b1, 1'b0, 1'b0, 1);

`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    // Step 3: bad checksum, then recovery.
    do_reset();
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    exp_q.push_back({11'd0, 16'h1234});
    send_queued();
    check_status("s3_badchk", 1'b0, 1'b1, 1'b1, 1);
    send_byte(8'hA5, 1'b1);
    check("s3_err_clear", 32'(err), 32'd0);
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    exp_q.push_back({11'd0, 16'h1234});
    exp_q.push_back({11'd1, 16'hABCD});
    send_queued();
    check_status("s3_ok", 1'b1, 1'b0, 1'b0, 2);
`endif

    // Step 4: oversize length, then zero length.
    do_reset();
    tx_q = '{8'hA5, 8'h08, 8'h01};
    send_queued();
    check_status("s4_len", 1'b0, 1'b1, 1'b1, 0);
    tx_q = '{8'hA5, 8'h00, 8'h00};
    add_chk(8'h00);
    send_queued();
    check_status("s4_zero", 1'b1, 1'b0, 1'b0, 0);

    // Step 5: framing error, then inter-byte timeout.
    do_reset();
    send_byte(8'hA5, 1'b0);
    repeat (200) @(negedge clk);
    check_status("s5_frame", 1'b0, 1'b1, 1'b0, 0);
    tx_q = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_queued();
    repeat (600) @(negedge clk);
    check_status("s5_timeout", 1'b0, 1'b1, 1'b1, 0);
    step1_frame();
    check_status("s5_ok", 1'b1, 1'b0, 1'b0, 2);

    // Step 6: reset mid-frame, then input ignored once done.
    do_reset();
    tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
    send_queued();
    do_reset();
    check_reset_values("s6_rst");
    tx_q = '{8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_queued();
    check_status("s6_after_rst", 1'b0, 1'b1, 1'b0, 0);
    step1_frame();
    check_status("s6_ok", 1'b1, 1'b0, 1'b0, 2);
    send_byte(8'hA5, 1'b1);
    check_status("s6_done_ignores", 1'b1, 1'b0, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
